// File: rtl/qtr_array_scheduler.sv
// Round-robin sequencer for N QTR RC reflectance channels: pulses stp per channel, waits for
// eop or a watchdog timeout, captures Qt counts and publishes each complete sweep atomically.
module qtr_array_scheduler #(
    parameter int unsigned N      = 8,
    parameter int unsigned W      = 8,
    parameter int unsigned TO_W   = 15,
    parameter int unsigned TO_CYC = 26000,
    parameter int unsigned PER_W  = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [PER_W-1:0] i_period,
    input  logic [N-1:0]     i_eop,
    input  logic [N*W-1:0]   i_qt_in,
    output logic [N-1:0]     o_stp,
    output logic             o_led_on,
    output logic [N*W-1:0]   o_data_out,
    output logic             o_sweep_done,
    output logic             o_busy,
    output logic [N-1:0]     o_timeout_err,
    output logic             o_overrun
);

    localparam int unsigned CH_W = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_ch;
    logic [CH_W-1:0]     w_ch_nxt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [PER_W-1:0]    r_per_cnt;
    logic [N*W-1:0]      r_shadow;
    logic [N-1:0]        r_tmo_sh;
    logic [N-1:0]        r_stp;
    logic                r_led_on;
    logic [N*W-1:0]      r_data_out;
    logic                r_sweep_done;
    logic                r_busy;
    logic [N-1:0]        r_timeout_err;
    logic                r_overrun;
    logic                w_eop_sel;
    logic                w_to_hit;
    logic                w_sweep_load;

    assign w_eop_sel    = i_eop[r_ch];
    assign w_to_hit     = (r_to_cnt == TO_W'(TO_CYC - 1));
    assign w_sweep_load = (w_state_nxt == S_START) && ((r_state == S_IDLE) || (r_state == S_GAP));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        case (r_state)
            S_IDLE:  if (i_en) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_eop_sel) begin
                    w_state_nxt = S_CAPT;
                end else if (w_to_hit) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_CAPT:  w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (r_ch == CH_W'(N - 1)) begin
                    w_ch_nxt    = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_ch_nxt    = r_ch + CH_W'(1);
                    w_state_nxt = S_START;
                end
            end
            S_DONE:  w_state_nxt = S_GAP;
            S_GAP: begin
                if (r_per_cnt == '0) begin
                    w_state_nxt = i_en ? S_START : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Watchdog, period pacing and per-channel shadow capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt  <= '0;
            r_per_cnt <= '0;
            r_shadow  <= '0;
            r_tmo_sh  <= '0;
        end else begin
            if (r_state == S_START) begin
                r_to_cnt <= '0;
            end else if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            // Loading on entry makes START(ch0)-to-START(ch0) exactly period+1 cycles
            if (w_sweep_load) begin
                r_per_cnt <= i_period;
            end else if (r_per_cnt != '0) begin
                r_per_cnt <= r_per_cnt - PER_W'(1);
            end

            if ((r_state == S_WAIT) && (w_state_nxt == S_NEXT)) begin
                r_shadow[r_ch*W +: W] <= {W{1'b1}};
                r_tmo_sh[r_ch]        <= 1'b1;
            end else if (r_state == S_CAPT) begin
                r_shadow[r_ch*W +: W] <= i_qt_in[r_ch*W +: W];
                r_tmo_sh[r_ch]        <= 1'b0;
            end
        end
    end

    // Outputs registered from the next state so they align with the state they describe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stp         <= '0;
            r_led_on      <= 1'b0;
            r_busy        <= 1'b0;
            r_sweep_done  <= 1'b0;
            r_data_out    <= '0;
            r_timeout_err <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_stp        <= (w_state_nxt == S_START) ? (N'(1) << w_ch_nxt) : '0;
            r_led_on     <= (w_state_nxt inside {S_START, S_WAIT, S_CAPT, S_NEXT});
            r_busy       <= !(w_state_nxt inside {S_IDLE, S_GAP});
            r_sweep_done <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                r_data_out    <= r_shadow;
                r_timeout_err <= r_tmo_sh;
            end
            if ((r_state == S_DONE) && (r_per_cnt == '0) && (i_period != '0)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_stp         = r_stp;
    assign o_led_on      = r_led_on;
    assign o_busy        = r_busy;
    assign o_sweep_done  = r_sweep_done;
    assign o_data_out    = r_data_out;
    assign o_timeout_err = r_timeout_err;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_qtr_array_scheduler.sv
// Directed bench for qtr_array_scheduler with N=4 channel models (eop 50 cycles after stp).
module tb_qtr_array_scheduler;

    localparam int unsigned N      = 4;
    localparam int unsigned W      = 8;
    localparam int unsigned TO_W   = 15;
    localparam int unsigned TO_CYC = 300;
    localparam int unsigned PER_W  = 20;
    localparam int          D      = 50;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             en     = 1'b0;
    logic [PER_W-1:0] period = '0;
    logic [N-1:0]     eop    = '0;
    logic [N*W-1:0]   qt_in  = 32'h281E140A;
    logic [N-1:0]     o_stp;
    logic             o_led_on;
    logic [N*W-1:0]   o_data_out;
    logic             o_sweep_done;
    logic             o_busy;
    logic [N-1:0]     o_timeout_err;
    logic             o_overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cnt[N];
    logic [N-1:0] never = '0;
    logic [N-1:0] stp_q[$];
    int           stp_c[$];

    qtr_array_scheduler #(
        .N(N), .W(W), .TO_W(TO_W), .TO_CYC(TO_CYC), .PER_W(PER_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_period     (period),
        .i_eop        (eop),
        .i_qt_in      (qt_in),
        .o_stp        (o_stp),
        .o_led_on     (o_led_on),
        .o_data_out   (o_data_out),
        .o_sweep_done (o_sweep_done),
        .o_busy       (o_busy),
        .o_timeout_err(o_timeout_err),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Channel models: one-cycle eop D cycles after stp; also logs every stp pulse
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            eop[k] = 1'b0;
            if (o_stp[k]) begin
                cnt[k] = never[k] ? 0 : D;
            end else if (cnt[k] > 0) begin
                cnt[k]--;
                if (cnt[k] == 0) eop[k] = 1'b1;
            end
        end
        if (o_stp != '0) begin
            stp_q.push_back(o_stp);
            stp_c.push_back(cyc);
        end
    end

    task automatic settle();
        en = 1'b0;
        repeat (1300) @(negedge clk);
        stp_q.delete();
        stp_c.delete();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int t;
        for (t = 0; t < budget && o_sweep_done !== 1'b1; t++) @(negedge clk);
        ok = (o_sweep_done === 1'b1);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (o_stp !== '0 || o_led_on !== 1'b0 || o_busy !== 1'b0 || o_sweep_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: stp=%b led=%b busy=%b done=%b, required all 0",
                     o_stp, o_led_on, o_busy, o_sweep_done);
        end
        checks++;
        if (o_data_out !== '0 || o_timeout_err !== '0 || o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: data=%h tmo=%b ovr=%b, required 0",
                     o_data_out, o_timeout_err, o_overrun);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || stp_q.size() != 0) begin
            failures++;
            $display("FAIL idle_no_en: busy=%b stp_count=%0d, required 0/0", o_busy, stp_q.size());
        end
    endtask

    task automatic test_sweep();
        bit ok;
        int dc;
        period = '0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_done(400, ok);
        dc = cyc;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sweep_done_seen: no sweep_done in 400 cycles");
        end
        checks++;
        if (o_data_out !== 32'h281E140A || o_timeout_err !== 4'b0000) begin
            failures++;
            $display("FAIL sweep_data: data=%h tmo=%b, required 281e140a/0000", o_data_out, o_timeout_err);
        end
        checks++;
        if (o_led_on !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL done_flags: led=%b busy=%b, required 0/1", o_led_on, o_busy);
        end
        checks++;
        if (stp_q.size() != 4 || stp_q[0] !== 4'b0001 || stp_q[1] !== 4'b0010 ||
            stp_q[2] !== 4'b0100 || stp_q[3] !== 4'b1000) begin
            failures++;
            $display("FAIL stp_order: count=%0d, required 4 pulses 0001,0010,0100,1000", stp_q.size());
        end else begin
            checks++;
            if (stp_c[1] - stp_c[0] != 53 || stp_c[3] - stp_c[2] != 53 || dc - stp_c[0] != 212) begin
                failures++;
                $display("FAIL sweep_timing: ch_gap=%0d done_lat=%0d, required 53/212",
                         stp_c[1] - stp_c[0], dc - stp_c[0]);
            end
        end
        repeat (100) @(negedge clk);
        checks++;
        if (stp_q.size() != 4 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_sweep_idle: stp_count=%0d busy=%b, required 4/0", stp_q.size(), o_busy);
        end
        settle();
    endtask

    task automatic test_timeout();
        bit ok;
        never[2] = 1'b1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_done(1200, ok);
        checks++;
        if (!ok || o_data_out !== 32'h28FF140A || o_timeout_err !== 4'b0100) begin
            failures++;
            $display("FAIL timeout_data: done=%b data=%h tmo=%b, required 1/28ff140a/0100",
                     ok, o_data_out, o_timeout_err);
        end
        checks++;
        if (stp_q.size() != 4 || stp_c[3] - stp_c[2] != TO_CYC + 2 || stp_c[1] - stp_c[0] != 53) begin
            failures++;
            $display("FAIL timeout_hold: stp_count=%0d, required 4 with ch2 gap %0d", stp_q.size(), TO_CYC + 2);
        end
        never[2] = 1'b0;
        settle();
    endtask

    task automatic test_period();
        bit ok;
        int dcyc[3];
        period = PER_W'(1000);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(2000, ok);
            dcyc[i] = cyc;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL period_done_%0d: no sweep_done within 2000 cycles", i);
            end
            @(negedge clk);
        end
        checks++;
        if (dcyc[1] - dcyc[0] != 1001 || dcyc[2] - dcyc[1] != 1001) begin
            failures++;
            $display("FAIL period_spacing: %0d,%0d, required 1001,1001", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
        end
        checks++;
        if (o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL period_overrun: overrun=%b, required 0", o_overrun);
        end
        settle();
    endtask

    task automatic test_overrun();
        bit ok;
        int dcyc[3];
        period = PER_W'(100);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(500, ok);
            dcyc[i] = cyc;
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL overrun_done_%0d: no sweep_done within 500 cycles", i);
            end
            @(negedge clk);
        end
        checks++;
        if (o_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag: overrun=%b, required 1", o_overrun);
        end
        checks++;
        if (dcyc[1] - dcyc[0] != 214 || dcyc[2] - dcyc[1] != 214) begin
            failures++;
            $display("FAIL b2b_spacing: %0d,%0d, required 214,214", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
        end
        settle();
    endtask

    task automatic test_async_reset();
        int t;
        period = '0;
        en = 1'b1;
        for (t = 0; t < 200 && o_stp[1] !== 1'b1; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++;
        if (o_led_on !== 1'b1 || o_busy !== 1'b1 || o_overrun !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: led=%b busy=%b ovr=%b, required 1/1/1", o_led_on, o_busy, o_overrun);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_stp !== '0 || o_led_on !== 1'b0 || o_busy !== 1'b0 || o_sweep_done !== 1'b0 ||
            o_data_out !== '0 || o_timeout_err !== '0 || o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: led=%b busy=%b data=%h tmo=%b ovr=%b, required all 0",
                     o_led_on, o_busy, o_data_out, o_timeout_err, o_overrun);
        end
        stp_q.delete();
        stp_c.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (t = 0; t < 50 && stp_q.size() == 0; t++) @(negedge clk);
        checks++;
        if (stp_q.size() == 0 || stp_q[0] !== 4'b0001) begin
            failures++;
            $display("FAIL restart_ch0: first stp=%b count=%0d, required 0001",
                     (stp_q.size() != 0) ? stp_q[0] : 4'bxxxx, stp_q.size());
        end
        settle();
    endtask

    task automatic test_en_drop();
        bit ok;
        int t;
        period = '0;
        en = 1'b1;
        for (t = 0; t < 200 && o_stp[1] !== 1'b1; t++) @(negedge clk);
        en = 1'b0;
        wait_done(400, ok);
        checks++;
        if (!ok || o_data_out !== 32'h281E140A || o_timeout_err !== 4'b0000) begin
            failures++;
            $display("FAIL en_drop_publish: done=%b data=%h tmo=%b, required 1/281e140a/0000",
                     ok, o_data_out, o_timeout_err);
        end
        repeat (3) @(negedge clk);
        stp_q.delete();
        stp_c.delete();
        repeat (300) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || stp_q.size() != 0) begin
            failures++;
            $display("FAIL en_drop_idle: busy=%b stp_count=%0d, required 0/0", o_busy, stp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_timeout();
        test_period();
        test_overrun();
        test_async_reset();
        test_en_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
